sram_arb_ctrl: RTL and testbench

Two-port arbiter and bus sequencer for the board's external asynchronous SRAM (16-bit, byte lanes via lb_n/ub_n). It accepts word read/write requests from two on-chip requesters (A: CPU-side/UI writer, B: LED/display scanner) and grants them round-robin. It generates correctly ordered ce_n/oe_n/we_n/lb_n/ub_n strobes with setup, strobe and hold phases. It sits between the requesters and the SRAM pins, replacing ad-hoc direct pin driving.

---
 rtl/sram_arb_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_sram_arb_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arb_ctrl.sv
// Two-requester round-robin arbiter and strobe sequencer for a 16-bit asynchronous SRAM.
// Define SRAM_ARB_FIXED_PRIO_EN to make requester A always win simultaneous requests.
module sram_arb_ctrl #(
    parameter int unsigned ADDR_W   = 7,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned WAIT_CYC = 2
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    input  logic [1:0]        a_be,
    output logic              a_ack,
    output logic [DATA_W-1:0] a_rdata,

    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    input  logic [1:0]        b_be,
    output logic              b_ack,
    output logic [DATA_W-1:0] b_rdata,

    output logic              busy,

    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_dq_o,
    output logic              sram_dq_oe,
    input  logic [DATA_W-1:0] sram_dq_i,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic              sram_lb_n,
    output logic              sram_ub_n
);

    localparam int unsigned Half = DATA_W / 2;
    localparam logic [3:0] WaitLast = 4'(WAIT_CYC - 1);

    if (WAIT_CYC < 1 || WAIT_CYC > 15) begin : g_bad_wait
        $error("WAIT_CYC must be in 1..15");
    end

    typedef enum logic [1:0] {StIdle, StSetup, StAccess, StHold} state_e;

    state_e state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic we_q, we_d;
    logic [1:0] be_q, be_d;
    logic gnt_b_q, gnt_b_d;
    logic pick_b;

    logic a_ack_q, a_ack_d, b_ack_q, b_ack_d, busy_q, busy_d;
    logic [DATA_W-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] dq_o_q, dq_o_d;
    logic dq_oe_q, dq_oe_d;
    logic ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d, lb_n_q, lb_n_d, ub_n_q, ub_n_d;
    logic [DATA_W-1:0] rd_masked;

`ifdef SRAM_ARB_FIXED_PRIO_EN
    assign pick_b = b_req && !a_req;
`else
    logic last_b_q, last_b_d;

    // On contention, serve whichever requester did not win last time.
    assign pick_b = b_req && (!a_req || !last_b_q);
`endif

    // Disabled byte lanes read back as zero.
    always_comb begin
        rd_masked = sram_dq_i;
        if (!be_q[0]) rd_masked[Half-1:0] = '0;
        if (!be_q[1]) rd_masked[DATA_W-1:Half] = '0;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        be_d      = be_q;
        gnt_b_d   = gnt_b_q;
        a_ack_d   = 1'b0;
        b_ack_d   = 1'b0;
        a_rdata_d = a_rdata_q;
        b_rdata_d = b_rdata_q;
        addr_d    = addr_q;
        dq_o_d    = dq_o_q;
        dq_oe_d   = dq_oe_q;
        ce_n_d    = ce_n_q;
        oe_n_d    = oe_n_q;
        we_n_d    = we_n_q;
        lb_n_d    = lb_n_q;
        ub_n_d    = ub_n_q;
`ifndef SRAM_ARB_FIXED_PRIO_EN
        last_b_d  = last_b_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (a_req || b_req) begin
                    gnt_b_d = pick_b;
                    we_d    = pick_b ? b_we : a_we;
                    be_d    = pick_b ? b_be : a_be;
                    addr_d  = pick_b ? b_addr : a_addr;
                    if (we_d) dq_o_d = pick_b ? b_wdata : a_wdata;
                    dq_oe_d = we_d;
                    ce_n_d  = 1'b0;
                    lb_n_d  = ~be_d[0];
                    ub_n_d  = ~be_d[1];
`ifndef SRAM_ARB_FIXED_PRIO_EN
                    last_b_d = pick_b;
`endif
                    state_d = StSetup;
                end
            end
            StSetup: begin
                cnt_d = WaitLast;
                if (we_q) we_n_d = 1'b0;
                else      oe_n_d = 1'b0;
                state_d = StAccess;
            end
            StAccess: begin
                if (cnt_q == 4'd0) begin
                    oe_n_d = 1'b1;
                    we_n_d = 1'b1;
                    if (gnt_b_q) begin
                        b_ack_d = 1'b1;
                        if (!we_q) b_rdata_d = rd_masked;
                    end else begin
                        a_ack_d = 1'b1;
                        if (!we_q) a_rdata_d = rd_masked;
                    end
                    state_d = StHold;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StHold: begin
                // Release the bus one cycle after the strobes so data hold is met.
                ce_n_d  = 1'b1;
                lb_n_d  = 1'b1;
                ub_n_d  = 1'b1;
                dq_oe_d = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            we_q      <= 1'b0;
            be_q      <= 2'b00;
            gnt_b_q   <= 1'b0;
            a_ack_q   <= 1'b0;
            b_ack_q   <= 1'b0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
            busy_q    <= 1'b0;
            addr_q    <= '0;
            dq_o_q    <= '0;
            dq_oe_q   <= 1'b0;
            ce_n_q    <= 1'b1;
            oe_n_q    <= 1'b1;
            we_n_q    <= 1'b1;
            lb_n_q    <= 1'b1;
            ub_n_q    <= 1'b1;
`ifndef SRAM_ARB_FIXED_PRIO_EN
            last_b_q  <= 1'b1;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            we_q      <= we_d;
            be_q      <= be_d;
            gnt_b_q   <= gnt_b_d;
            a_ack_q   <= a_ack_d;
            b_ack_q   <= b_ack_d;
            a_rdata_q <= a_rdata_d;
            b_rdata_q <= b_rdata_d;
            busy_q    <= busy_d;
            addr_q    <= addr_d;
            dq_o_q    <= dq_o_d;
            dq_oe_q   <= dq_oe_d;
            ce_n_q    <= ce_n_d;
            oe_n_q    <= oe_n_d;
            we_n_q    <= we_n_d;
            lb_n_q    <= lb_n_d;
            ub_n_q    <= ub_n_d;
`ifndef SRAM_ARB_FIXED_PRIO_EN
            last_b_q  <= last_b_d;
`endif
        end
    end

    assign a_ack      = a_ack_q;
    assign b_ack      = b_ack_q;
    assign a_rdata    = a_rdata_q;
    assign b_rdata    = b_rdata_q;
    assign busy       = busy_q;
    assign sram_addr  = addr_q;
    assign sram_dq_o  = dq_o_q;
    assign sram_dq_oe = dq_oe_q;
    assign sram_ce_n  = ce_n_q;
    assign sram_oe_n  = oe_n_q;
    assign sram_we_n  = we_n_q;
    assign sram_lb_n  = lb_n_q;
    assign sram_ub_n  = ub_n_q;

endmodule

// File: tb/tb_sram_arb_ctrl.sv
// Scoreboard bench for sram_arb_ctrl with a behavioural async SRAM that commits on we_n rise.
module tb_sram_arb_ctrl;

    localparam int unsigned AW = 7;
    localparam int unsigned WC = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
    logic [AW-1:0] a_addr = '0, b_addr = '0;
    logic [15:0] a_wdata = '0, b_wdata = '0;
    logic [1:0] a_be = '0, b_be = '0;
    logic a_ack, b_ack, busy;
    logic [15:0] a_rdata, b_rdata;
    logic [AW-1:0] sram_addr;
    logic [15:0] sram_dq_o, sram_dq_i;
    logic sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n;

    sram_arb_ctrl #(.ADDR_W(AW), .DATA_W(16), .WAIT_CYC(WC)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_be(a_be),
        .a_ack(a_ack), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_be(b_be),
        .b_ack(b_ack), .b_rdata(b_rdata),
        .busy(busy),
        .sram_addr(sram_addr), .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe),
        .sram_dq_i(sram_dq_i),
        .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
        .sram_lb_n(sram_lb_n), .sram_ub_n(sram_ub_n)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // SRAM model: read drives every lane; write commits when we_n rises with ce_n still low.
    logic [15:0] mem [0:(1<<AW)-1];
    logic prev_wr = 1'b0;
    logic [AW-1:0] prev_addr;
    logic [15:0] prev_data;
    logic prev_lb, prev_ub;

    assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr] : 16'h0BAD;

    initial for (int i = 0; i < (1 << AW); i++) mem[i] = 16'h0000;

    always @(negedge clk) begin
        if (prev_wr && sram_we_n && !sram_ce_n) begin
            if (prev_lb) mem[prev_addr][7:0] = prev_data[7:0];
            if (prev_ub) mem[prev_addr][15:8] = prev_data[15:8];
        end
        prev_wr   = !sram_we_n && !sram_ce_n && sram_dq_oe;
        prev_addr = sram_addr;
        prev_data = sram_dq_o;
        prev_lb   = !sram_lb_n;
        prev_ub   = !sram_ub_n;
    end

    // Scoreboard of expected acks in grant order.
    typedef struct packed {
        logic        port;
        logic        rd;
        logic [15:0] data;
    } exp_t;
    exp_t exp_q[$];

    always @(negedge clk) begin
        if (a_ack || b_ack) begin
            if (a_ack && b_ack) chk("dual_ack", {a_ack, b_ack}, 2'b01);
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_ack: got a_ack=%0d b_ack=%0d, expected none", a_ack, b_ack);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("ack_port", b_ack, e.port);
                if (e.rd) chk("rdata", b_ack ? b_rdata : a_rdata, e.data);
            end
        end
    end

    logic mon_en = 1'b0;
    int oe_low_cnt = 0;
    int dq_oe_cnt = 0;
    always @(negedge clk) if (mon_en) begin
        if (!sram_oe_n) oe_low_cnt++;
        if (sram_dq_oe) dq_oe_cnt++;
    end

    task automatic push_exp(input logic port, input logic rd, input logic [15:0] data);
        exp_t e;
        e.port = port;
        e.rd = rd;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic set_req(input logic port, input logic req, input logic we,
                           input logic [AW-1:0] addr, input logic [15:0] wd, input logic [1:0] be);
        if (port) begin
            b_req = req; b_we = we; b_addr = addr; b_wdata = wd; b_be = be;
        end else begin
            a_req = req; a_we = we; a_addr = addr; a_wdata = wd; a_be = be;
        end
    endtask

    task automatic run_txn(input logic port, input logic we, input logic [AW-1:0] addr,
                           input logic [15:0] wd, input logic [1:0] be, input logic [15:0] exp_rd);
        logic ok;
        ok = 1'b0;
        push_exp(port, !we, exp_rd);
        @(posedge clk); #1;
        set_req(port, 1'b1, we, addr, wd, be);
        for (int i = 0; i < 30 && !ok; i++) begin
            @(negedge clk);
            if (port ? b_ack : a_ack) ok = 1'b1;
        end
        chk("ack_seen", ok, 1'b1);
        @(posedge clk); #1;
        set_req(port, 1'b0, 1'b0, '0, '0, 2'b00);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_req(1'b0, 1'b0, 1'b0, '0, '0, 2'b00);
        set_req(1'b1, 1'b0, 1'b0, '0, '0, 2'b00);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int na, nb;
        logic drop_a, drop_b;

        do_reset();
        @(negedge clk);
        chk("rst_strobes", {sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n, sram_dq_oe, busy},
            7'b1111100);
        chk("rst_bus", {sram_addr, sram_dq_o}, '0);
        chk("rst_rdata", {a_rdata, b_rdata}, 32'h0);

        // Timed write by A: SETUP at N+1, we_n low N+2..N+3, ack at N+4, turnaround at N+5.
        push_exp(1'b0, 1'b0, 16'h0000);
        @(posedge clk); #1;
        set_req(1'b0, 1'b1, 1'b1, 7'h05, 16'hA55A, 2'b11);
        @(negedge clk);
        chk("n0_idle", {sram_ce_n, busy}, 2'b10);
        @(negedge clk);
        chk("n1_setup", {sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n, sram_dq_oe, busy},
            7'b0110011);
        chk("n1_addr_data", {sram_addr, sram_dq_o}, {7'h05, 16'hA55A});
        @(negedge clk);
        chk("n2_we_low", {sram_we_n, sram_oe_n, a_ack}, 3'b010);
        @(negedge clk);
        chk("n3_we_low", {sram_we_n, sram_oe_n, a_ack}, 3'b010);
        @(negedge clk);
        chk("n4_hold", {a_ack, sram_we_n, sram_ce_n, sram_dq_oe}, 4'b1101);
        @(posedge clk); #1;
        set_req(1'b0, 1'b0, 1'b0, '0, '0, 2'b00);
        @(negedge clk);
        chk("n5_turnaround", {sram_dq_oe, sram_ce_n, sram_we_n, busy, a_ack}, 5'b01100);
        chk("mem_a55a", mem[5], 16'hA55A);

        // B read: two oe_n cycles, data bus never driven.
        oe_low_cnt = 0;
        dq_oe_cnt = 0;
        mon_en = 1'b1;
        run_txn(1'b1, 1'b0, 7'h05, 16'h0000, 2'b11, 16'hA55A);
        mon_en = 1'b0;
        chk("b_read_oe_cycles", oe_low_cnt, WC);
        chk("b_read_no_dq_oe", dq_oe_cnt, 0);

        // Byte-lane write and masked reads.
        run_txn(1'b0, 1'b1, 7'h05, 16'h1234, 2'b01, 16'h0000);
        chk("mem_a534", mem[5], 16'hA534);
        run_txn(1'b0, 1'b0, 7'h05, 16'h0000, 2'b11, 16'hA534);
        run_txn(1'b0, 1'b0, 7'h05, 16'h0000, 2'b10, 16'hA500);
        run_txn(1'b1, 1'b0, 7'h05, 16'h0000, 2'b00, 16'h0000);

        // Reset during the second ACCESS cycle of a write aborts it without an ack.
        @(posedge clk); #1;
        set_req(1'b0, 1'b1, 1'b1, 7'h05, 16'hFFFF, 2'b11);
        repeat (4) @(negedge clk);
        chk("abort_in_access", {sram_we_n, sram_ce_n}, 2'b00);
        rst_n = 1'b0;
        set_req(1'b0, 1'b0, 1'b0, '0, '0, 2'b00);
        @(posedge clk); #1;
        chk("abort_strobes", {sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n, sram_dq_oe, a_ack},
            7'b1111100);
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_txn(1'b0, 1'b0, 7'h05, 16'h0000, 2'b11, 16'hA534);

        // Contention after reset: A holds req for two grants, B for one.
        do_reset();
`ifdef SRAM_ARB_FIXED_PRIO_EN
        push_exp(1'b0, 1'b0, 16'h0);
        push_exp(1'b0, 1'b0, 16'h0);
        push_exp(1'b1, 1'b0, 16'h0);
`else
        push_exp(1'b0, 1'b0, 16'h0);
        push_exp(1'b1, 1'b0, 16'h0);
        push_exp(1'b0, 1'b0, 16'h0);
`endif
        @(posedge clk); #1;
        set_req(1'b0, 1'b1, 1'b1, 7'h0A, 16'h1111, 2'b11);
        set_req(1'b1, 1'b1, 1'b1, 7'h0B, 16'h2222, 2'b11);
        na = 0;
        nb = 0;
        for (int i = 0; i < 60 && !(na == 2 && nb == 1); i++) begin
            @(negedge clk);
            drop_a = 1'b0;
            drop_b = 1'b0;
            if (a_ack) begin
                na++;
                if (na == 2) drop_a = 1'b1;
            end
            if (b_ack) begin
                nb++;
                drop_b = 1'b1;
            end
            @(posedge clk); #1;
            if (drop_a) a_req = 1'b0;
            if (drop_b) b_req = 1'b0;
        end
        chk("contention_a_acks", na, 2);
        chk("contention_b_acks", nb, 1);
        repeat (3) @(negedge clk);
        chk("mem_0a", mem[10], 16'h1111);
        chk("mem_0b", mem[11], 16'h2222);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
